// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle logic/arithmetic plus an iterative SHIFT_STEP-per-cycle shifter.
// Optional signed-overflow flag on add/sub is built when ALU_OVF_EN is defined.
module alu_exec #(
    parameter int SHIFT_STEP = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        ready,
    input  logic        flush,
    input  logic [7:0]  ALUsel,
    input  logic        UseImm,
    input  logic        imm_zext,
    input  logic        lui,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic [15:0] imm,
    input  logic [4:0]  shamt,
    input  logic        chk_ovf,
    output logic        out_valid,
    output logic [31:0] result
`ifdef ALU_OVF_EN
    ,
    output logic        ovf
`endif
);

    localparam logic [7:0] ALU_ADD  = 8'h01;
    localparam logic [7:0] ALU_SUB  = 8'h02;
    localparam logic [7:0] ALU_SLT  = 8'h03;
    localparam logic [7:0] ALU_SLTU = 8'h04;
    localparam logic [7:0] ALU_AND  = 8'h05;
    localparam logic [7:0] ALU_OR   = 8'h06;
    localparam logic [7:0] ALU_XOR  = 8'h07;
    localparam logic [7:0] ALU_NOR  = 8'h08;
    localparam logic [7:0] ALU_SLL  = 8'h09;
    localparam logic [7:0] ALU_SRL  = 8'h0A;
    localparam logic [7:0] ALU_SRA  = 8'h0B;

    localparam logic [4:0] STEP = 5'(SHIFT_STEP);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t      state;
    logic [31:0] sh_val;
    logic [4:0]  remain;
    logic [1:0]  sh_kind;

    logic [31:0] op_a, op_b, sum, diff, alu_res, first_val, next_val;
    logic [4:0]  amt, first_n, step_n;
    logic [1:0]  kind;
    logic        is_shift;

    // kind: 0 = sll, 1 = srl, 2 = sra; an arithmetic shift of the running value
    // keeps replicating the original bit 31, so no separate fill bit is stored.
    function automatic logic [31:0] do_shift(input logic [31:0] v, input logic [1:0] k,
                                             input logic [4:0] n);
        case (k)
            2'd0:    do_shift = v << n;
            2'd1:    do_shift = v >> n;
            2'd2:    do_shift = 32'($signed(v) >>> n);
            default: do_shift = v;
        endcase
    endfunction

    always_comb begin
        op_a = rs_data;
        if (lui)
            op_b = {imm, 16'h0};
        else if (UseImm && imm_zext)
            op_b = {16'h0, imm};
        else if (UseImm)
            op_b = {{16{imm[15]}}, imm};
        else
            op_b = rt_data;

        sum  = op_a + op_b;
        diff = op_a - op_b;

        is_shift = 1'b1;
        kind     = 2'd0;
        alu_res  = 32'h0;
        case (ALUsel)
            ALU_ADD:  alu_res = sum;
            ALU_SUB:  alu_res = diff;
            ALU_SLT:  alu_res = {31'h0, $signed(op_a) < $signed(op_b)};
            ALU_SLTU: alu_res = {31'h0, op_a < op_b};
            ALU_AND:  alu_res = op_a & op_b;
            ALU_OR:   alu_res = op_a | op_b;
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_NOR:  alu_res = ~(op_a | op_b);
            ALU_SLL:  kind = 2'd0;
            ALU_SRL:  kind = 2'd1;
            ALU_SRA:  kind = 2'd2;
            default:  alu_res = 32'h0;
        endcase
        if (ALUsel != ALU_SLL && ALUsel != ALU_SRL && ALUsel != ALU_SRA)
            is_shift = 1'b0;

        // The first step is taken on the accepting edge, so latency is ceil(amt/STEP).
        amt       = UseImm ? shamt : rs_data[4:0];
        first_n   = (amt > STEP) ? STEP : amt;
        first_val = do_shift(rt_data, kind, first_n);
        step_n    = (remain > STEP) ? STEP : remain;
        next_val  = do_shift(sh_val, sh_kind, step_n);
    end

`ifdef ALU_OVF_EN
    logic ovf_calc;
    always_comb begin
        ovf_calc = 1'b0;
        if (chk_ovf && ALUsel == ALU_ADD)
            ovf_calc = (op_a[31] == op_b[31]) && (sum[31] != op_a[31]);
        else if (chk_ovf && ALUsel == ALU_SUB)
            ovf_calc = (op_a[31] != op_b[31]) && (diff[31] != op_a[31]);
    end
`else
    logic unused_chk_ovf;
    assign unused_chk_ovf = chk_ovf;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ready     <= 1'b1;
            out_valid <= 1'b0;
            result    <= 32'h0;
            sh_val    <= 32'h0;
            remain    <= 5'h0;
            sh_kind   <= 2'd0;
`ifdef ALU_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            out_valid <= 1'b0;
`ifdef ALU_OVF_EN
            ovf       <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (in_valid && !flush) begin
                        if (is_shift && amt > STEP) begin
                            sh_val  <= first_val;
                            remain  <= amt - STEP;
                            sh_kind <= kind;
                            state   <= SHIFT;
                            ready   <= 1'b0;
                        end else begin
                            out_valid <= 1'b1;
                            result    <= is_shift ? first_val : alu_res;
`ifdef ALU_OVF_EN
                            ovf       <= ovf_calc;
`endif
                        end
                    end
                end
                SHIFT: begin
                    if (flush) begin
                        state <= IDLE;
                        ready <= 1'b1;
                    end else if (remain <= STEP) begin
                        result    <= next_val;
                        out_valid <= 1'b1;
                        state     <= IDLE;
                        ready     <= 1'b1;
                    end else begin
                        sh_val <= next_val;
                        remain <= remain - STEP;
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
